hamming_error_injector: RTL and testbench

- Channel-model stage directly upstream of the Hamming decoder. It accepts encoded code words and flips 0, 1 or 2 bits per word, selected by a mode input.
- The corrupted word leaves through a registered valid/ready output slice and feeds the decoder's enStream input.
- It also outputs the applied error mask and keeps saturating statistics counters, so the bench can compare what was injected against what the decoder corrected.

---
 rtl/hamming_pkg.sv | 23 ++
 rtl/lfsr_gen.sv | 31 +++
 rtl/hamming_error_injector.sv | 140 ++++++++++++++
 tb/tb_hamming_error_injector.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming channel-model and codec blocks.
package hamming_pkg;

   typedef enum logic [1:0] {
      MODE_PASS   = 2'd0,
      MODE_FORCED = 2'd1,
      MODE_RAND1  = 2'd2,
      MODE_RAND2  = 2'd3
   } mode_e;

   localparam int unsigned HAM_W     = 11;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Bit 1 is the MSB, so position p lives at value bit HAM_W-p.
   function automatic logic [1:HAM_W] pos_to_mask(input logic [3:0] pos);
      logic [1:HAM_W] m;
      m = '0;
      if (pos >= 4'd1 && 32'(pos) <= HAM_W)
         m = HAM_W'(1) << (HAM_W - 32'(pos));
      return m;
   endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Galois LFSR that steps only when told to; a zero seed is replaced by 1.
module lfsr_gen
   import hamming_pkg::*;
#(
   parameter int unsigned          LFSR_W = 16,
   parameter logic [LFSR_W-1:0]    SEED   = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              advance,
   output logic [LFSR_W-1:0] value
);

   localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? LFSR_W'(1) : SEED;

   logic [LFSR_W-1:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (advance)
         lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_W'(LFSR_TAPS) : '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= SEED_NZ;
      else     lfsr_q <= lfsr_d;
   end

   assign value = lfsr_q;

endmodule

// File: rtl/hamming_error_injector.sv
// Flips 0, 1 or 2 bits of each code word on its way to the decoder and keeps
// saturating injection statistics; output is a one-deep registered slice.
module hamming_error_injector
   import hamming_pkg::*;
#(
   parameter int unsigned       W      = HAM_W,
   parameter int unsigned       LFSR_W = 16,
   parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
   parameter int unsigned       CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:W]       in_word,
   input  logic [1:0]       mode,
   input  logic [3:0]       err_pos,
   input  logic [7:0]       threshold,
   input  logic             clear_stats,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:W]       out_word,
   output logic [1:W]       out_mask,
   output logic [1:0]       out_nerr,
   output logic [CNT_W-1:0] words_cnt,
   output logic [CNT_W-1:0] err_words_cnt,
   output logic [CNT_W-1:0] flips_cnt
);

   logic              accept;
   logic [LFSR_W-1:0] lfsr_val;
   logic              inject;
   int unsigned       p1, p2;
   logic [1:W]        gen_mask;
   logic [1:0]        gen_nerr;

   logic             valid_q, valid_d;
   logic [1:W]       word_q, word_d, mask_q, mask_d;
   logic [1:0]       nerr_q, nerr_d;
   logic [CNT_W-1:0] words_q, words_d, errw_q, errw_d, flips_q, flips_d;

   function automatic logic [1:W] onehot(input int unsigned p);
      logic [1:W] m;
      m = '0;
      if (p >= 1 && p <= W) m = W'(1) << (W - p);
      return m;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                input logic [1:0] inc);
      logic [CNT_W:0] s;
      s = {1'b0, c} + (CNT_W+1)'(inc);
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   lfsr_gen #(.LFSR_W(LFSR_W), .SEED(SEED)) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .advance (accept),
      .value   (lfsr_val)
   );

   // p2 offset is 1..W-1 from p1, so the two positions can never coincide.
   always_comb begin
      inject   = lfsr_val[7:0] < threshold;
      p1       = (32'(lfsr_val[15:8]) % W) + 1;
      p2       = ((p1 + 32'(lfsr_val[11:8] ^ lfsr_val[3:0]) % (W - 1)) % W) + 1;
      gen_mask = '0;
      unique case (mode_e'(mode))
         MODE_PASS:   gen_mask = '0;
         MODE_FORCED: gen_mask = onehot(32'(err_pos));
         MODE_RAND1:  gen_mask = inject ? onehot(p1) : '0;
         MODE_RAND2:  gen_mask = inject ? (onehot(p1) | onehot(p2)) : '0;
         default:     gen_mask = '0;
      endcase
      gen_nerr = 2'($countones(gen_mask));
   end

   always_comb begin
      valid_d = valid_q;
      word_d  = word_q;
      mask_d  = mask_q;
      nerr_d  = nerr_q;
      if (accept) begin
         valid_d = 1'b1;
         word_d  = in_word ^ gen_mask;
         mask_d  = gen_mask;
         nerr_d  = gen_nerr;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_comb begin
      words_d = words_q;
      errw_d  = errw_q;
      flips_d = flips_q;
      if (clear_stats) begin
         words_d = '0;
         errw_d  = '0;
         flips_d = '0;
      end else if (accept) begin
         words_d = sat_add(words_q, 2'd1);
         errw_d  = sat_add(errw_q, {1'b0, gen_nerr != 2'd0});
         flips_d = sat_add(flips_q, gen_nerr);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         word_q  <= '0;
         mask_q  <= '0;
         nerr_q  <= '0;
         words_q <= '0;
         errw_q  <= '0;
         flips_q <= '0;
      end else begin
         valid_q <= valid_d;
         word_q  <= word_d;
         mask_q  <= mask_d;
         nerr_q  <= nerr_d;
         words_q <= words_d;
         errw_q  <= errw_d;
         flips_q <= flips_d;
      end
   end

   assign out_valid     = valid_q;
   assign out_word      = word_q;
   assign out_mask      = mask_q;
   assign out_nerr      = nerr_q;
   assign words_cnt     = words_q;
   assign err_words_cnt = errw_q;
   assign flips_cnt     = flips_q;

endmodule

// File: tb/tb_hamming_error_injector.sv
// Randomized bench for hamming_error_injector against a behavioural model.
module tb_hamming_error_injector;

   localparam int unsigned W = 11;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid, out_ready, clear_stats;
   logic [1:W]     in_word;
   logic [1:0]     mode;
   logic [3:0]     err_pos;
   logic [7:0]     threshold;

   logic           in_ready, out_valid;
   logic [1:W]     out_word, out_mask;
   logic [1:0]     out_nerr;
   logic [15:0]    words_cnt, err_words_cnt, flips_cnt;

   logic           s_in_ready, s_out_valid;
   logic [1:W]     s_out_word, s_out_mask;
   logic [1:0]     s_out_nerr;
   logic [3:0]     s_words, s_errw, s_flips;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   // model state
   bit          m_valid;
   logic [1:W]  m_word, m_mask;
   int unsigned m_nerr;
   int unsigned lfsr_m;
   int unsigned c_words, c_err, c_flips;

   always #5 clk = ~clk;

   hamming_error_injector #(.W(W), .LFSR_W(16), .SEED(16'hACE1), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_word(in_word), .mode(mode), .err_pos(err_pos), .threshold(threshold),
      .clear_stats(clear_stats), .out_valid(out_valid), .out_ready(out_ready),
      .out_word(out_word), .out_mask(out_mask), .out_nerr(out_nerr),
      .words_cnt(words_cnt), .err_words_cnt(err_words_cnt), .flips_cnt(flips_cnt)
   );

   hamming_error_injector #(.W(W), .LFSR_W(16), .SEED(16'hACE1), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_word(in_word), .mode(mode), .err_pos(err_pos), .threshold(threshold),
      .clear_stats(clear_stats), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_word(s_out_word), .out_mask(s_out_mask), .out_nerr(s_out_nerr),
      .words_cnt(s_words), .err_words_cnt(s_errw), .flips_cnt(s_flips)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned sat(input int unsigned c, input int unsigned mx);
      return (c > mx) ? mx : c;
   endfunction

   function automatic int unsigned lfsr_next(input int unsigned l);
      int unsigned r;
      r = l / 2;
      if (l % 2 == 1) r = r ^ 32'hB400;
      return r;
   endfunction

   function automatic int unsigned bitpos(input int unsigned p);
      return 1 << (W - p);
   endfunction

   function automatic int unsigned model_mask(input int unsigned l, input int unsigned md,
                                              input int unsigned ep, input int unsigned th);
      int unsigned lo, hi, x, p1, p2;
      bit inj;
      lo  = l % 256;
      hi  = (l / 256) % 256;
      inj = lo < th;
      p1  = hi % W + 1;
      x   = ((l / 256) % 16) ^ (l % 16);
      p2  = ((p1 - 1 + 1 + x % (W - 1)) % W) + 1;
      case (md)
         1:       return (ep >= 1 && ep <= W) ? bitpos(ep) : 0;
         2:       return inj ? bitpos(p1) : 0;
         3:       return inj ? (bitpos(p1) | bitpos(p2)) : 0;
         default: return 0;
      endcase
   endfunction

   function automatic void model_reset();
      m_valid = 0;
      m_word  = '0;
      m_mask  = '0;
      m_nerr  = 0;
      lfsr_m  = 32'hACE1;
      c_words = 0;
      c_err   = 0;
      c_flips = 0;
   endfunction

   task automatic check_state();
      chk("in_ready", in_ready, !m_valid || out_ready);
      chk("s_in_ready", s_in_ready, !m_valid || out_ready);
      chk("out_valid", out_valid, m_valid);
      chk("s_out_valid", s_out_valid, m_valid);
      if (m_valid) begin
         chk("out_word", out_word, m_word);
         chk("out_mask", out_mask, m_mask);
         chk("out_nerr", out_nerr, m_nerr);
         chk("s_out_word", s_out_word, m_word);
         chk("s_out_mask", s_out_mask, m_mask);
         chk("s_out_nerr", s_out_nerr, m_nerr);
      end
      chk("words_cnt", words_cnt, sat(c_words, 65535));
      chk("err_words_cnt", err_words_cnt, sat(c_err, 65535));
      chk("flips_cnt", flips_cnt, sat(c_flips, 65535));
      chk("s_words", s_words, sat(c_words, 15));
      chk("s_errw", s_errw, sat(c_err, 15));
      chk("s_flips", s_flips, sat(c_flips, 15));
   endtask

   // One clock: check at negedge, predict the coming edge, return at posedge+1.
   task automatic step(output bit acc);
      int unsigned mk, cnt;
      @(negedge clk);
      check_state();
      acc = in_valid && (!m_valid || out_ready);
      mk  = 0;
      if (acc) begin
         mk     = model_mask(lfsr_m, mode, err_pos, threshold);
         lfsr_m = lfsr_next(lfsr_m);
      end
      cnt = $countones(mk);
      if (clear_stats) begin
         c_words = 0; c_err = 0; c_flips = 0;
      end else if (acc) begin
         c_words++;
         if (cnt != 0) c_err++;
         c_flips += cnt;
      end
      if (acc) begin
         m_valid = 1;
         m_mask  = W'(mk);
         m_word  = in_word ^ m_mask;
         m_nerr  = cnt;
      end else if (out_ready) begin
         m_valid = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int unsigned n, input logic [1:0] md, input logic [7:0] th,
                      input bit rnd);
      int unsigned got, cyc;
      bit a;
      got = 0;
      cyc = 0;
      mode = md;
      threshold = th;
      while (got < n && cyc < 8 * n + 64) begin
         in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_word   = W'($urandom);
         err_pos   = 4'($urandom);
         step(a);
         if (a) got++;
         cyc++;
      end
      chk("run_budget", got, n);
      in_valid = 1'b0;
   endtask

   initial begin
      bit a;
      logic [15:0] e0;

      rst = 1'b1; in_valid = 0; out_ready = 0; clear_stats = 0;
      in_word = '0; mode = 2'd0; err_pos = 4'd0; threshold = 8'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_word", out_word, 0);
      chk("rst_out_mask", out_mask, 0);
      chk("rst_out_nerr", out_nerr, 0);
      chk("rst_words", words_cnt, 0);
      rst = 1'b0;

      // pass-through
      out_ready = 1; in_valid = 1; mode = 2'd0; in_word = 11'b10101010101;
      step(a);
      in_valid = 0;
      chk("m0_word", out_word, 11'b10101010101);
      chk("m0_nerr", out_nerr, 0);
      chk("m0_words", words_cnt, 1);
      chk("m0_errw", err_words_cnt, 0);

      // forced single flip, then out-of-range position
      in_valid = 1; mode = 2'd1; err_pos = 4'd3; in_word = '0;
      step(a);
      chk("m1_word", out_word, 11'b00100000000);
      chk("m1_nerr", out_nerr, 1);
      chk("m1_flips", flips_cnt, 1);
      err_pos = 4'd12;
      step(a);
      chk("m1_pos12", out_mask, 0);

      // stall with input pending, then release for back-to-back transfers
      mode = 2'd3; threshold = 8'd255; in_word = W'($urandom);
      step(a);
      out_ready = 0;
      for (int i = 0; i < 5; i++) begin
         in_word = W'($urandom);
         step(a);
         chk("stall_in_ready", in_ready, 0);
      end
      out_ready = 1;
      for (int i = 0; i < 5; i++) begin
         in_word = W'($urandom);
         step(a);
         chk("no_bubble", out_valid, 1);
      end
      in_valid = 0;
      step(a);

      run(200, 2'd1, 8'd0, 1);
      run(1000, 2'd3, 8'd255, 1);
      chk("sat15", s_words, 15);
      run(1000, 2'd2, 8'd255, 1);
      e0 = err_words_cnt;
      run(200, 2'd2, 8'd0, 1);
      chk("th0_noinj", err_words_cnt - e0, 0);

      // clear on an accept edge: that word is not counted
      out_ready = 1; in_valid = 1; clear_stats = 1; mode = 2'd3; threshold = 8'd255;
      step(a);
      clear_stats = 0; in_valid = 0;
      chk("clr_words", words_cnt, 0);
      chk("clr_flips", flips_cnt, 0);

      run(4096, 2'd2, 8'd128, 1);
      chk("th128_rng", (err_words_cnt >= 16'd1898 && err_words_cnt <= 16'd2198), 1);

      // asynchronous reset while a word is held
      out_ready = 1; in_valid = 1; mode = 2'd3; threshold = 8'd255;
      step(a);
      in_valid = 0; out_ready = 0;
      #2 rst = 1'b1;
      #1;
      chk("rst_async_valid", out_valid, 0);
      chk("rst_async_s_valid", s_out_valid, 0);
      chk("rst_async_words", words_cnt, 0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      run(20, 2'd3, 8'd255, 0);
      out_ready = 1;
      step(a);
      step(a);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
